// File: rtl/sram_responder.sv
// Device-side cycle model of the external 32-bit data SRAM.
// Accepts controller cycles and returns read data on the shared bus after a programmable latency.
module sram_responder #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 18,
   parameter int DEPTH_BITS   = 10,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] sram_address,
   input  logic                  sram_w_en,
   inout  wire  [DATA_WIDTH-1:0] sram_dq,
   output logic                  rd_valid,
   output logic [15:0]           read_count,
   output logic [15:0]           write_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRIVE = 2'd2
   } state_t;

   localparam logic [2:0] RELOAD = 3'(READ_LATENCY - 1);

   state_t                  state, state_next;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    we_q;
   logic [2:0]              wait_cnt, wait_cnt_next;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    new_access, new_access_next;
   logic                    latch;
   logic                    addr_change;
   logic [DEPTH_BITS-1:0]   word_idx;

   logic [DATA_WIDTH-1:0]   mem [2**DEPTH_BITS];

   // Change detection uses the full address even though the array aliases.
   assign addr_change = (sram_address != addr_q);
   assign word_idx    = sram_address[DEPTH_BITS-1:0];

   // The write-enable term releases the bus in the same cycle a write begins.
   assign rd_valid = (state == DRIVE) && sram_w_en;
   assign sram_dq  = rd_valid ? rdata_q : {DATA_WIDTH{1'bz}};

   always_comb begin
      state_next      = state;
      wait_cnt_next   = wait_cnt;
      new_access_next = new_access;
      latch           = 1'b0;
      if (!sram_w_en) begin
         state_next      = IDLE;
         new_access_next = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (new_access || addr_change) begin
                  wait_cnt_next   = RELOAD;
                  new_access_next = 1'b0;
                  if (READ_LATENCY == 1) begin
                     state_next = DRIVE;
                     latch      = 1'b1;
                  end else begin
                     state_next = WAIT;
                  end
               end
            end
            WAIT: begin
               if (addr_change) begin
                  wait_cnt_next = RELOAD;
               end else if (wait_cnt == 3'd1) begin
                  state_next = DRIVE;
                  latch      = 1'b1;
               end else begin
                  wait_cnt_next = wait_cnt - 3'd1;
               end
            end
            DRIVE: begin
               if (addr_change) begin
                  wait_cnt_next = RELOAD;
                  if (READ_LATENCY == 1) begin
                     latch = 1'b1;
                  end else begin
                     state_next = WAIT;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         wait_cnt    <= 3'd0;
         new_access  <= 1'b1;
         we_q        <= 1'b1;
         addr_q      <= '0;
         read_count  <= 16'd0;
         write_count <= 16'd0;
      end else begin
         state      <= state_next;
         wait_cnt   <= wait_cnt_next;
         new_access <= new_access_next;
         we_q       <= sram_w_en;
         addr_q     <= sram_address;
         if (latch && (read_count != 16'hFFFF))
            read_count <= read_count + 16'd1;
         if (!sram_w_en && we_q && (write_count != 16'hFFFF))
            write_count <= write_count + 16'd1;
      end
   end

   // Array is kept out of reset so its contents survive it.
   always_ff @(posedge clk) begin
      if (rst && !sram_w_en)
         mem[word_idx] <= sram_dq;
      if (rst && latch)
         rdata_q <= mem[word_idx];
   end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: latency-2 instance plus a latency-1 instance.
module tb_sram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [17:0] addr, addr1;
   logic        w_en, w_en1;
   logic        tb_en, tb1_en;
   logic [31:0] tb_dq, tb1_dq;
   wire  [31:0] sram_dq, sram_dq1;
   logic        rd_valid, rd_valid1;
   logic [15:0] read_count, write_count, read_count1, write_count1;
   int          checks = 0;
   int          failures = 0;

   assign sram_dq  = tb_en  ? tb_dq  : 32'bz;
   assign sram_dq1 = tb1_en ? tb1_dq : 32'bz;

   always #5 clk = ~clk;

   sram_responder #(.READ_LATENCY(2)) dut (
      .clk(clk), .rst(rst), .sram_address(addr), .sram_w_en(w_en),
      .sram_dq(sram_dq), .rd_valid(rd_valid),
      .read_count(read_count), .write_count(write_count)
   );

   sram_responder #(.READ_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .sram_address(addr1), .sram_w_en(w_en1),
      .sram_dq(sram_dq1), .rd_valid(rd_valid1),
      .read_count(read_count1), .write_count(write_count1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      w_en  = 1'b1; tb_en  = 1'b0;
      w_en1 = 1'b1; tb1_en = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic write_word(input logic [17:0] a, input logic [31:0] d);
      addr = a; tb_dq = d; tb_en = 1'b1; w_en = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0; w_en = 1'b1; tb_en = 1'b0; addr = 18'd0;
      w_en1 = 1'b1; tb1_en = 1'b0; addr1 = 18'd0;
      tick(); tick();
      rst = 1'b1;
      write_word(18'd9, 32'h13579BDF);
      rst = 1'b0; tb_dq = 32'hDEADBEEF;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (rd_valid !== 1'b0 || write_count !== 16'd0 || read_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_state cyc%0d: rd_valid=%b wc=%0d rc=%0d, required 0/0/0", i, rd_valid, write_count, read_count);
         end
      end
      rst = 1'b1; w_en = 1'b1; tb_en = 1'b0;
      tick(); tick();
      checks++;
      if (rd_valid !== 1'b1 || sram_dq !== 32'h13579BDF) begin
         failures++;
         $display("FAIL reset_no_write: rd_valid=%b dq=%h, required 1 13579bdf", rd_valid, sram_dq);
      end
      checks++;
      if (read_count !== 16'd1 || write_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_counts: rc=%0d wc=%0d, required 1 0", read_count, write_count);
      end
   endtask

   task automatic test_write_read();
      do_reset();
      write_word(18'h00005, 32'h12345678);
      w_en = 1'b1; tb_en = 1'b0;
      checks++;
      if (rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL wr_rd_idle: rd_valid=%b, required 0", rd_valid);
      end
      tick();
      checks++;
      if (rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL wr_rd_early: rd_valid=%b, required 0", rd_valid);
      end
      tick();
      checks++;
      if (rd_valid !== 1'b1 || sram_dq !== 32'h12345678) begin
         failures++;
         $display("FAIL wr_rd_data: rd_valid=%b dq=%h, required 1 12345678", rd_valid, sram_dq);
      end
      checks++;
      if (read_count !== 16'd1 || write_count !== 16'd1) begin
         failures++;
         $display("FAIL wr_rd_counts: rc=%0d wc=%0d, required 1 1", read_count, write_count);
      end
      $display("write_read: addr=5 data=%h rc=%0d wc=%0d", sram_dq, read_count, write_count);
   endtask

   task automatic test_restart();
      do_reset();
      write_word(18'd3, 32'h0000000A);
      write_word(18'd4, 32'h0000000B);
      w_en = 1'b1; tb_en = 1'b0; addr = 18'd3;
      tick();
      checks++;
      if (rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL restart_wait: rd_valid=%b, required 0", rd_valid);
      end
      addr = 18'd4;
      tick();
      checks++;
      if (rd_valid !== 1'b0 || read_count !== 16'd0) begin
         failures++;
         $display("FAIL restart_reload: rd_valid=%b rc=%0d, required 0 0", rd_valid, read_count);
      end
      tick();
      checks++;
      if (rd_valid !== 1'b1 || sram_dq !== 32'h0000000B || read_count !== 16'd1) begin
         failures++;
         $display("FAIL restart_data: rd_valid=%b dq=%h rc=%0d, required 1 0000000b 1", rd_valid, sram_dq, read_count);
      end
      $display("restart: addr 3->4 data=%h rc=%0d", sram_dq, read_count);
   endtask

   task automatic test_write_during_drive();
      do_reset();
      write_word(18'd7, 32'h77777777);
      w_en = 1'b1; tb_en = 1'b0;
      tick(); tick();
      checks++;
      if (rd_valid !== 1'b1 || sram_dq !== 32'h77777777) begin
         failures++;
         $display("FAIL wdd_drive: rd_valid=%b dq=%h, required 1 77777777", rd_valid, sram_dq);
      end
      w_en = 1'b0; tb_en = 1'b1; tb_dq = 32'h00000055;
      #1;
      checks++;
      if (rd_valid !== 1'b0 || sram_dq !== 32'h00000055) begin
         failures++;
         $display("FAIL wdd_release: rd_valid=%b dq=%h, required 0 00000055", rd_valid, sram_dq);
      end
      tick();
      w_en = 1'b1; tb_en = 1'b0;
      checks++;
      if (rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL wdd_idle: rd_valid=%b, required 0", rd_valid);
      end
      tick(); tick();
      checks++;
      if (rd_valid !== 1'b1 || sram_dq !== 32'h00000055) begin
         failures++;
         $display("FAIL wdd_readback: rd_valid=%b dq=%h, required 1 00000055", rd_valid, sram_dq);
      end
      checks++;
      if (read_count !== 16'd2 || write_count !== 16'd2) begin
         failures++;
         $display("FAIL wdd_counts: rc=%0d wc=%0d, required 2 2", read_count, write_count);
      end
      $display("write_during_drive: addr=7 data=%h rc=%0d wc=%0d", sram_dq, read_count, write_count);
   endtask

   task automatic test_alias_burst();
      do_reset();
      write_word(18'h00400, 32'h0000CAFE);
      tick(); tick();
      checks++;
      if (write_count !== 16'd1) begin
         failures++;
         $display("FAIL burst_count: wc=%0d, required 1", write_count);
      end
      w_en = 1'b1; tb_en = 1'b0; addr = 18'd0;
      tick(); tick();
      checks++;
      if (rd_valid !== 1'b1 || sram_dq !== 32'h0000CAFE) begin
         failures++;
         $display("FAIL alias_read: rd_valid=%b dq=%h, required 1 0000cafe", rd_valid, sram_dq);
      end
      addr = 18'h00400;
      tick();
      checks++;
      if (rd_valid !== 1'b0 || read_count !== 16'd1) begin
         failures++;
         $display("FAIL alias_fulladdr_restart: rd_valid=%b rc=%0d, required 0 1", rd_valid, read_count);
      end
      tick();
      checks++;
      if (rd_valid !== 1'b1 || sram_dq !== 32'h0000CAFE || read_count !== 16'd2) begin
         failures++;
         $display("FAIL alias_reread: rd_valid=%b dq=%h rc=%0d, required 1 0000cafe 2", rd_valid, sram_dq, read_count);
      end
      $display("alias_burst: addr=400 data=%h rc=%0d wc=%0d", sram_dq, read_count, write_count);
   endtask

   task automatic test_saturation();
      do_reset();
      force dut.read_count  = 16'hFFFE;
      force dut.write_count = 16'hFFFE;
      #1;
      release dut.read_count;
      release dut.write_count;
      write_word(18'd1, 32'h00000001);
      checks++;
      if (write_count !== 16'hFFFF) begin
         failures++;
         $display("FAIL sat_write_top: wc=%h, required ffff", write_count);
      end
      w_en = 1'b1; tb_en = 1'b0;
      tick(); tick();
      checks++;
      if (read_count !== 16'hFFFF) begin
         failures++;
         $display("FAIL sat_read_top: rc=%h, required ffff", read_count);
      end
      addr = 18'd2;
      tick(); tick();
      write_word(18'd2, 32'h00000002);
      w_en = 1'b1; tb_en = 1'b0;
      checks++;
      if (read_count !== 16'hFFFF || write_count !== 16'hFFFF) begin
         failures++;
         $display("FAIL sat_hold: rc=%h wc=%h, required ffff ffff", read_count, write_count);
      end
      $display("saturation: rc=%h wc=%h", read_count, write_count);
   endtask

   task automatic test_latency1();
      do_reset();
      addr1 = 18'd2; tb1_dq = 32'h22222222; tb1_en = 1'b1; w_en1 = 1'b0;
      tick();
      addr1 = 18'd3; tb1_dq = 32'h33333333;
      tick();
      w_en1 = 1'b1; tb1_en = 1'b0; addr1 = 18'd2;
      checks++;
      if (rd_valid1 !== 1'b0) begin
         failures++;
         $display("FAIL lat1_idle: rd_valid=%b, required 0", rd_valid1);
      end
      tick();
      checks++;
      if (rd_valid1 !== 1'b1 || sram_dq1 !== 32'h22222222 || read_count1 !== 16'd1) begin
         failures++;
         $display("FAIL lat1_first: rd_valid=%b dq=%h rc=%0d, required 1 22222222 1", rd_valid1, sram_dq1, read_count1);
      end
      addr1 = 18'd3;
      tick();
      checks++;
      if (rd_valid1 !== 1'b1 || sram_dq1 !== 32'h33333333 || read_count1 !== 16'd2) begin
         failures++;
         $display("FAIL lat1_relatch: rd_valid=%b dq=%h rc=%0d, required 1 33333333 2", rd_valid1, sram_dq1, read_count1);
      end
      addr1 = 18'd2;
      tick();
      checks++;
      if (sram_dq1 !== 32'h22222222 || read_count1 !== 16'd3 || write_count1 !== 16'd1) begin
         failures++;
         $display("FAIL lat1_back_to_back: dq=%h rc=%0d wc=%0d, required 22222222 3 1", sram_dq1, read_count1, write_count1);
      end
      $display("latency1: data=%h rc=%0d wc=%0d", sram_dq1, read_count1, write_count1);
   endtask

   initial begin
      tb_dq = '0; tb1_dq = '0;
      test_reset();
      test_write_read();
      test_restart();
      test_write_during_drive();
      test_alias_burst();
      test_saturation();
      test_latency1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
